// File: rtl/vga_timing_compositor.sv
// VGA raster timing generator with per-frame shadowed configuration and an
// N-layer fixed-priority compositor aligned to a fixed renderer latency.
module vga_timing_compositor #(
    parameter int unsigned CW          = 12,
    parameter int unsigned COLOR_W     = 8,
    parameter int unsigned NUM_LAYERS  = 4,
    parameter int unsigned PIPE_DELAY  = 2,
    // Shadow reset timing; defaults give 640x480@60.
    parameter int unsigned H_TOTAL_DEF = 799,
    parameter int unsigned H_SYNC_DEF  = 96,
    parameter int unsigned H_START_DEF = 144,
    parameter int unsigned H_END_DEF   = 784,
    parameter int unsigned V_TOTAL_DEF = 524,
    parameter int unsigned V_SYNC_DEF  = 2,
    parameter int unsigned V_START_DEF = 35,
    parameter int unsigned V_END_DEF   = 515
) (
    input  logic                               clk,
    input  logic                               reset_n,
    input  logic [CW-1:0]                      cfg_h_total,
    input  logic [CW-1:0]                      cfg_h_sync,
    input  logic [CW-1:0]                      cfg_h_start,
    input  logic [CW-1:0]                      cfg_h_end,
    input  logic [CW-1:0]                      cfg_v_total,
    input  logic [CW-1:0]                      cfg_v_sync,
    input  logic [CW-1:0]                      cfg_v_start,
    input  logic [CW-1:0]                      cfg_v_end,
    input  logic                               cfg_hs_pol,
    input  logic                               cfg_vs_pol,
    output logic [CW-1:0]                      pixel_x,
    output logic [CW-1:0]                      pixel_y,
    output logic                               pixel_valid,
    output logic                               sof,
    output logic                               vblank_start,
    output logic [15:0]                        frame_cnt,
    input  logic [NUM_LAYERS*3*COLOR_W-1:0]    layer_rgb,
    input  logic [NUM_LAYERS-1:0]              layer_valid,
    output logic                               vga_hs,
    output logic                               vga_vs,
    output logic                               vga_de,
    output logic [COLOR_W-1:0]                 vga_r,
    output logic [COLOR_W-1:0]                 vga_g,
    output logic [COLOR_W-1:0]                 vga_b
);

    localparam int unsigned PIX_W = 3 * COLOR_W;
    // Sideband bundle carried down the delay line.
    localparam int unsigned SB_W  = 5;
    localparam int unsigned SB_DE = 4;
    localparam int unsigned SB_HS = 3;
    localparam int unsigned SB_VS = 2;
    localparam int unsigned SB_HP = 1;
    localparam int unsigned SB_VP = 0;

    // Shadowed timing configuration
    logic [CW-1:0] h_total_q, h_sync_q, h_start_q, h_end_q;
    logic [CW-1:0] v_total_q, v_sync_q, v_start_q, v_end_q;
    logic          hs_pol_q, vs_pol_q;

    // Raster counters
    logic [CW-1:0] h_count_q, h_count_d;
    logic [CW-1:0] v_count_q, v_count_d;
    logic          line_end_c, frame_end_c;

    // Stage-0 registers
    logic [CW-1:0] pixel_x_q, pixel_x_d;
    logic [CW-1:0] pixel_y_q, pixel_y_d;
    logic          pixel_valid_q, pixel_valid_d;
    logic          sof_q, sof_d;
    logic          vblank_q, vblank_d;
    logic [15:0]   frame_cnt_q, frame_cnt_d;
    logic [SB_W-2:0] sb0_q, sb0_d;
    logic          h_act_c, v_act_c;

    // Sideband delay line and output stage
    logic [PIPE_DELAY-1:0][SB_W-1:0] sb_dly_q;
    logic [SB_W-1:0]                 sb_tail_c;
    logic [PIX_W-1:0]                sel_rgb_c;
    logic                            sel_found_c;
    logic                            vga_hs_q, vga_hs_d;
    logic                            vga_vs_q, vga_vs_d;
    logic                            vga_de_q, vga_de_d;
    logic [PIX_W-1:0]                rgb_q, rgb_d;

    // Shadow load at the last count of the frame, so a new setting starts cleanly
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            h_total_q <= CW'(H_TOTAL_DEF);
            h_sync_q  <= CW'(H_SYNC_DEF);
            h_start_q <= CW'(H_START_DEF);
            h_end_q   <= CW'(H_END_DEF);
            v_total_q <= CW'(V_TOTAL_DEF);
            v_sync_q  <= CW'(V_SYNC_DEF);
            v_start_q <= CW'(V_START_DEF);
            v_end_q   <= CW'(V_END_DEF);
            hs_pol_q  <= 1'b0;
            vs_pol_q  <= 1'b0;
        end else if (frame_end_c) begin
            h_total_q <= cfg_h_total;
            h_sync_q  <= cfg_h_sync;
            h_start_q <= cfg_h_start;
            h_end_q   <= cfg_h_end;
            v_total_q <= cfg_v_total;
            v_sync_q  <= cfg_v_sync;
            v_start_q <= cfg_v_start;
            v_end_q   <= cfg_v_end;
            hs_pol_q  <= cfg_hs_pol;
            vs_pol_q  <= cfg_vs_pol;
        end
    end

    // Horizontal/vertical counter next state
    always_comb begin
        line_end_c  = (h_count_q == h_total_q);
        frame_end_c = line_end_c && (v_count_q == v_total_q);
        h_count_d   = h_count_q + CW'(1);
        v_count_d   = v_count_q;
        if (line_end_c) begin
            h_count_d = '0;
            v_count_d = (v_count_q == v_total_q) ? '0 : v_count_q + CW'(1);
        end
    end

    // Raster counter registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            h_count_q <= '0;
            v_count_q <= '0;
        end else begin
            h_count_q <= h_count_d;
            v_count_q <= v_count_d;
        end
    end

    // Stage-0 decode of the counters
    always_comb begin
        h_act_c       = (h_count_q >= h_start_q) && (h_count_q < h_end_q);
        v_act_c       = (v_count_q >= v_start_q) && (v_count_q < v_end_q);
        pixel_valid_d = h_act_c && v_act_c;
        pixel_x_d     = pixel_valid_d ? h_count_q - h_start_q : '0;
        pixel_y_d     = pixel_valid_d ? v_count_q - v_start_q : '0;
        sof_d         = (h_count_q == '0) && (v_count_q == '0);
        vblank_d      = (h_count_q == '0) && (v_count_q == v_end_q);
        frame_cnt_d   = sof_d ? frame_cnt_q + 16'd1 : frame_cnt_q;
        // Sync activity travels with the polarity that was current for this count.
        sb0_d         = {h_count_q < h_sync_q, v_count_q < v_sync_q, hs_pol_q, vs_pol_q};
    end

    // Stage-0 registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pixel_x_q     <= '0;
            pixel_y_q     <= '0;
            pixel_valid_q <= 1'b0;
            sof_q         <= 1'b0;
            vblank_q      <= 1'b0;
            frame_cnt_q   <= '0;
            sb0_q         <= '0;
        end else begin
            pixel_x_q     <= pixel_x_d;
            pixel_y_q     <= pixel_y_d;
            pixel_valid_q <= pixel_valid_d;
            sof_q         <= sof_d;
            vblank_q      <= vblank_d;
            frame_cnt_q   <= frame_cnt_d;
            sb0_q         <= sb0_d;
        end
    end

    // Delay line matching the renderer latency
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sb_dly_q <= '0;
        end else begin
            sb_dly_q[0] <= {pixel_valid_q, sb0_q};
            for (int i = 1; i < PIPE_DELAY; i++) begin
                sb_dly_q[i] <= sb_dly_q[i-1];
            end
        end
    end

    // Priority select (lowest index wins) and sync level generation
    always_comb begin
        sb_tail_c   = sb_dly_q[PIPE_DELAY-1];
        sel_rgb_c   = '0;
        sel_found_c = 1'b0;
        for (int i = 0; i < NUM_LAYERS; i++) begin
            if (!sel_found_c && layer_valid[i]) begin
                sel_rgb_c   = layer_rgb[i*PIX_W +: PIX_W];
                sel_found_c = 1'b1;
            end
        end
        vga_de_d = sb_tail_c[SB_DE];
        vga_hs_d = sb_tail_c[SB_HS] ? sb_tail_c[SB_HP] : ~sb_tail_c[SB_HP];
        vga_vs_d = sb_tail_c[SB_VS] ? sb_tail_c[SB_VP] : ~sb_tail_c[SB_VP];
        rgb_d    = sb_tail_c[SB_DE] ? sel_rgb_c : '0;
    end

    // Output register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vga_hs_q <= 1'b1;
            vga_vs_q <= 1'b1;
            vga_de_q <= 1'b0;
            rgb_q    <= '0;
        end else begin
            vga_hs_q <= vga_hs_d;
            vga_vs_q <= vga_vs_d;
            vga_de_q <= vga_de_d;
            rgb_q    <= rgb_d;
        end
    end

    assign pixel_x      = pixel_x_q;
    assign pixel_y      = pixel_y_q;
    assign pixel_valid  = pixel_valid_q;
    assign sof          = sof_q;
    assign vblank_start = vblank_q;
    assign frame_cnt    = frame_cnt_q;
    assign vga_hs       = vga_hs_q;
    assign vga_vs       = vga_vs_q;
    assign vga_de       = vga_de_q;
    assign vga_r        = rgb_q[PIX_W-1 -: COLOR_W];
    assign vga_g        = rgb_q[2*COLOR_W-1 -: COLOR_W];
    assign vga_b        = rgb_q[COLOR_W-1:0];

endmodule

// File: tb/tb_vga_timing_compositor.sv
// Directed bench: a small-raster instance (20x10 counts) for function and
// shadowing, plus a default-timing instance for 640x480 line checks.
module tb_vga_timing_compositor;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    // Small raster: h 19/3/5/15, v 9/2/2/7
    logic [11:0] cfg_h_total = 12'd19, cfg_h_sync = 12'd3, cfg_h_start = 12'd5, cfg_h_end = 12'd15;
    logic [11:0] cfg_v_total = 12'd9,  cfg_v_sync = 12'd2, cfg_v_start = 12'd2, cfg_v_end = 12'd7;
    logic        cfg_hs_pol = 1'b0, cfg_vs_pol = 1'b0;
    logic [3:0]  lv = 4'b0001;

    logic [11:0] pixel_x, pixel_y;
    logic        pixel_valid, sof, vblank_start;
    logic [15:0] frame_cnt;
    logic        vga_hs, vga_vs, vga_de;
    logic [7:0]  vga_r, vga_g, vga_b;
    logic [95:0] layer_rgb;

    // Renderer model: two cycles of latency from pixel_x
    logic [11:0] px_d1, px_d2;
    always @(posedge clk) begin
        px_d1 <= pixel_x;
        px_d2 <= px_d1;
    end
    assign layer_rgb = {24'h0000FF, 24'h00FF00, 24'hFF0000, {px_d2[7:0], 8'h00, 8'h5A}};

    vga_timing_compositor #(
        .H_TOTAL_DEF(19), .H_SYNC_DEF(3), .H_START_DEF(5), .H_END_DEF(15),
        .V_TOTAL_DEF(9),  .V_SYNC_DEF(2), .V_START_DEF(2), .V_END_DEF(7)
    ) u_dut (
        .clk(clk), .reset_n(reset_n),
        .cfg_h_total(cfg_h_total), .cfg_h_sync(cfg_h_sync),
        .cfg_h_start(cfg_h_start), .cfg_h_end(cfg_h_end),
        .cfg_v_total(cfg_v_total), .cfg_v_sync(cfg_v_sync),
        .cfg_v_start(cfg_v_start), .cfg_v_end(cfg_v_end),
        .cfg_hs_pol(cfg_hs_pol), .cfg_vs_pol(cfg_vs_pol),
        .pixel_x(pixel_x), .pixel_y(pixel_y), .pixel_valid(pixel_valid),
        .sof(sof), .vblank_start(vblank_start), .frame_cnt(frame_cnt),
        .layer_rgb(layer_rgb), .layer_valid(lv),
        .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_de(vga_de),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b)
    );

    // Default-timing instance
    logic [11:0] d_px, d_py;
    logic        d_pv, d_sof, d_vbs, d_hs, d_vs, d_de;
    logic [15:0] d_fc;
    logic [7:0]  d_r, d_g, d_b;

    vga_timing_compositor u_def (
        .clk(clk), .reset_n(reset_n),
        .cfg_h_total(12'd799), .cfg_h_sync(12'd96), .cfg_h_start(12'd144), .cfg_h_end(12'd784),
        .cfg_v_total(12'd524), .cfg_v_sync(12'd2), .cfg_v_start(12'd35), .cfg_v_end(12'd515),
        .cfg_hs_pol(1'b0), .cfg_vs_pol(1'b0),
        .pixel_x(d_px), .pixel_y(d_py), .pixel_valid(d_pv),
        .sof(d_sof), .vblank_start(d_vbs), .frame_cnt(d_fc),
        .layer_rgb(96'h0), .layer_valid(4'h0),
        .vga_hs(d_hs), .vga_vs(d_vs), .vga_de(d_de),
        .vga_r(d_r), .vga_g(d_g), .vga_b(d_b)
    );

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after rising edge k (counted from reset release)
    task automatic go(input int k);
        if (cyc < k) begin
            while (cyc < k) begin
                @(posedge clk);
                cyc++;
            end
            #1;
        end
    endtask

    initial begin
        int c_de, c_hs, c_vs, c_sof;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_hs",    32'(vga_hs), 32'd1);
        check("rst_vs",    32'(vga_vs), 32'd1);
        check("rst_de",    32'(vga_de), 32'd0);
        check("rst_rgb",   32'({vga_r, vga_g, vga_b}), 32'd0);
        check("rst_fc",    32'(frame_cnt), 32'd0);
        check("rst_sof",   32'(sof), 32'd0);
        check("rst_pv",    32'(pixel_valid), 32'd0);
        check("rst_def_hs", 32'(d_hs), 32'd1);
        reset_n = 1'b1;
        cyc = 0;

        // Frame 1: first-pulse timing, latency, layer-0 passthrough
        go(1);   check("f1_sof",  32'(sof), 32'd1);
                 check("f1_fc",   32'(frame_cnt), 32'd1);
                 check("f1_pv0",  32'(pixel_valid), 32'd0);
        go(2);   check("f1_sof_end", 32'(sof), 32'd0);
        go(3);   check("hs_pipe_rst", 32'(vga_hs), 32'd1);
        go(4);   check("hs_first", 32'(vga_hs), 32'd0);
                 check("vs_first", 32'(vga_vs), 32'd0);
        go(7);   check("hs_end",  32'(vga_hs), 32'd1);
        go(45);  check("pv_pre",  32'(pixel_valid), 32'd0);
        go(46);  check("pv_first", 32'(pixel_valid), 32'd1);
                 check("px_first", 32'(pixel_x), 32'd0);
                 check("py_first", 32'(pixel_y), 32'd0);
        go(48);  check("de_pre",  32'(vga_de), 32'd0);
                 check("blank_rgb", 32'({vga_r, vga_g, vga_b}), 32'd0);
        go(49);  check("de_rise", 32'(vga_de), 32'd1);
                 check("rgb_px0", 32'({vga_r, vga_g, vga_b}), 32'h00005A);
        go(52);  check("r_px3",   32'(vga_r), 32'd3);
        go(58);  check("de_last", 32'(vga_de), 32'd1);
                 check("r_px9",   32'(vga_r), 32'd9);
        go(59);  check("de_fall", 32'(vga_de), 32'd0);
        go(66);  check("py_line1", 32'(pixel_y), 32'd1);
                 check("px_line1", 32'(pixel_x), 32'd0);
        go(140); check("vbs_pre", 32'(vblank_start), 32'd0);
        go(141); check("vbs",     32'(vblank_start), 32'd1);

        // Frame 2: whole-frame counts
        c_de = 0; c_hs = 0; c_vs = 0; c_sof = 0;
        for (int k = 201; k <= 403; k++) begin
            go(k);
            if (k == 201) check("f2_fc", 32'(frame_cnt), 32'd2);
            if (k <= 400 && sof) c_sof++;
            if (k >= 204) begin
                if (vga_de) c_de++;
                if (!vga_hs) c_hs++;
                if (!vga_vs) c_vs++;
            end
        end
        check("f2_de_cnt",  32'(c_de), 32'd50);
        check("f2_hs_cnt",  32'(c_hs), 32'd30);
        check("f2_vs_cnt",  32'(c_vs), 32'd40);
        check("f2_sof_cnt", 32'(c_sof), 32'd1);

        // Frame 3: priority, then mid-frame reprogramming
        lv = 4'b0110;
        go(448); check("prio_blank", 32'({vga_r, vga_g, vga_b}), 32'd0);
        go(449); check("prio_l1",    32'({vga_r, vga_g, vga_b}), 32'hFF0000);
        go(458); check("prio_l1b",   32'({vga_r, vga_g, vga_b}), 32'hFF0000);
        lv = 4'b0000;
        go(469); check("none_de",    32'(vga_de), 32'd1);
                 check("none_rgb",   32'({vga_r, vga_g, vga_b}), 32'd0);
        go(470);
        cfg_h_total = 12'd99;
        cfg_hs_pol  = 1'b1;
        go(504); check("shadow_pol_hold", 32'(vga_hs), 32'd0);
        go(600); check("f3_sof_pre", 32'(sof), 32'd0);
        go(601); check("f4_sof",     32'(sof), 32'd1);
                 check("f4_fc",      32'(frame_cnt), 32'd4);

        // Frame 4: 100-count lines, active-high hsync
        go(604); check("f4_hs_old",  32'(vga_hs), 32'd1);
        go(605); check("f4_hs_act",  32'(vga_hs), 32'd1);
        go(608); check("f4_hs_inact", 32'(vga_hs), 32'd0);
        go(646); check("f4_pv_old",  32'(pixel_valid), 32'd0);
        go(806); check("f4_pv",      32'(pixel_valid), 32'd1);
                 check("f4_px",      32'(pixel_x), 32'd0);
        go(820); check("f4_pv_h19",  32'(pixel_valid), 32'd0);
        go(906); check("f4_py",      32'(pixel_y), 32'd1);
        cfg_h_total = 12'd19;
        cfg_h_start = 12'd200;
        cfg_h_end   = 12'd200;
        go(1600); check("f4_sof_pre", 32'(sof), 32'd0);
        go(1601); check("f5_sof",     32'(sof), 32'd1);
                  check("f5_fc",      32'(frame_cnt), 32'd5);

        // Frame 5: empty active area, syncs keep running
        c_de = 0; c_hs = 0; c_vs = 0; c_sof = 0;
        for (int k = 1601; k <= 1803; k++) begin
            go(k);
            if (k <= 1800 && sof) c_sof++;
            if (k >= 1604) begin
                if (vga_de) c_de++;
                if (vga_hs) c_hs++;
                if (!vga_vs) c_vs++;
            end
        end
        check("deg_de_cnt",  32'(c_de), 32'd0);
        check("deg_hs_cnt",  32'(c_hs), 32'd30);
        check("deg_vs_cnt",  32'(c_vs), 32'd40);
        check("deg_sof_cnt", 32'(c_sof), 32'd1);

        // Asynchronous reset mid-line
        go(1810); check("pre_rst_fc", 32'(frame_cnt), 32'd6);
                  check("pre_rst_hs", 32'(vga_hs), 32'd0);
        #2 reset_n = 1'b0;
        #1;
        check("arst_hs",  32'(vga_hs), 32'd1);
        check("arst_fc",  32'(frame_cnt), 32'd0);
        check("arst_sof", 32'(sof), 32'd0);
        check("arst_px",  32'(pixel_x), 32'd0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        cyc = 0;
        go(1);   check("rel_sof", 32'(sof), 32'd1);
                 check("rel_fc",  32'(frame_cnt), 32'd1);

        // Default 640x480 timing: hsync width and active line width
        c_hs = 0;
        for (int k = 4; k <= 803; k++) begin
            go(k);
            if (!d_hs) c_hs++;
        end
        check("def_hs_cnt", 32'(c_hs), 32'd96);
        go(28144); check("def_pv_pre", 32'(d_pv), 32'd0);
        go(28145); check("def_pv",     32'(d_pv), 32'd1);
                   check("def_px",     32'(d_px), 32'd0);
                   check("def_py",     32'(d_py), 32'd0);
        c_de = 0;
        for (int k = 28146; k <= 28803; k++) begin
            go(k);
            if (d_de) c_de++;
        end
        check("def_de_cnt", 32'(c_de), 32'd640);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_timing_compositor.md
# vga_timing_compositor

Parametrised VGA timing generator with a built-in N-layer priority compositor. It produces raster counters, pixel coordinates and frame events for the layer renderers (background, food, characters). It takes their per-pixel colour and valid flags back after a fixed renderer latency. It outputs aligned hs/vs/de/RGB to the video DAC/HDMI transmitter. Timing is reprogrammable per frame through shadowed configuration inputs.

## Interface
- CW, 12: width of all counters and timing fields.
- COLOR_W, 8: bits per colour channel.
- NUM_LAYERS, 4: number of compositor inputs; layer 0 has the highest priority.
- PIPE_DELAY, 2: renderer latency in clk cycles from pixel_x/pixel_y to layer data; must be at least 1.

- clk  in  1  pixel clock.
- reset_n  in  1  asynchronous, active-low reset.
- cfg_h_total, cfg_h_sync, cfg_h_start, cfg_h_end  in  CW each  horizontal timing: last count, sync length, first active count, first inactive count.
- cfg_v_total, cfg_v_sync, cfg_v_start, cfg_v_end  in  CW each  vertical equivalents, in lines.
- cfg_hs_pol, cfg_vs_pol  in  1 each  active sync level; 0 means active-low.
- pixel_x, pixel_y  out  CW each  coordinate within the active area; 0 outside it.
- pixel_valid  out  1  stage-0 active-area flag.
- sof  out  1  one-cycle start-of-frame pulse.
- vblank_start  out  1  one-cycle pulse at the first count of the first inactive line.
- frame_cnt  out  16  frame counter.
- layer_rgb  in  NUM_LAYERS*3*COLOR_W  packed colour per layer, ordered {r,g,b}; layer k occupies bits [k*3*COLOR_W +: 3*COLOR_W].
- layer_valid  in  NUM_LAYERS  per-layer opaque flag.
- vga_hs, vga_vs, vga_de  out  1 each  aligned sync and data enable.
- vga_r, vga_g, vga_b  out  COLOR_W each  composited colour.

## Operation
- Shadow registers hold the active timing configuration.
  - Reset values are 640x480@60: h 799/96/144/784, v 524/2/35/515.
  - All cfg_* inputs, including polarities, are sampled into the shadows on the cycle where h_count==h_total and v_count==v_total.
  - A mid-frame cfg change therefore never affects the current frame.
- h_count counts 0..h_total and then wraps to 0.
- v_count increments when h_count==h_total and wraps to 0 after v_total.
- Stage-0 signals, all registered from the counters:
  - h_act = (h_start <= h_count < h_end).
  - v_act = (v_start <= v_count < v_end).
  - pixel_valid = h_act & v_act.
  - pixel_x = h_count - h_start when pixel_valid, else 0; pixel_y follows the same rule.
  - Raw hs is active while h_count < h_sync; raw vs is active while v_count < v_sync.
  - Sync output level = active ? pol : !pol.
- sof pulses when h_count==0 and v_count==0.
  - frame_cnt increments on the same cycle and wraps modulo 2^16.
- vblank_start pulses when h_count==0 and v_count==v_end.
- Degenerate configurations:
  - If start >= end, there is no active area and vga_de stays 0.
  - If end > total, the active region is truncated at the wrap.
  - If sync >= total+1, sync is held permanently active.
- Compositor:
  - The lowest-index layer with layer_valid=1 supplies the RGB.
  - If no layer is valid, the output is 0/0/0.
  - Colour is forced to 0 whenever the delayed de is 0, regardless of layer_valid.

## Timing
- Stage-0 hs/vs/de pass through a PIPE_DELAY-deep shift register, then the output register.
- layer_rgb and layer_valid arriving PIPE_DELAY cycles after their pixel_x/pixel_y go through one compositor register.
- Result: vga_hs/vs/de/r/g/b appear exactly PIPE_DELAY+1 cycles after the matching stage-0 pixel_valid/pixel_x, all aligned.
- The compositor is single-cycle: priority select plus output register. There is no backpressure.
- Reset is asynchronous and takes effect immediately, including mid-frame. Reset values:
  - Counters, pixel_x, pixel_y, pixel_valid, sof, vblank_start, frame_cnt, vga_de, vga_r/g/b and the delay line: 0.
  - vga_hs/vga_vs: inactive level for the default polarity (0 = active-low, so 1).
  - Shadows: default values.
- After reset release, counting starts at h_count=0, v_count=0. sof pulses within 1 cycle; frame_cnt reads 1 after that first pulse.

## Test plan
- Default configuration, 2 frames: frame period 420000 cycles; vga_hs low for 96 of every 800 cycles; vga_de high for 640 consecutive cycles on each of 480 lines; sof spacing 420000; frame_cnt increments by 1 per frame.
- Latency, PIPE_DELAY=2: pixel_x=0, pixel_valid=1 at cycle t -> vga_de rises at t+3. Feed layer_rgb = pixel_x on layer 0 -> vga_r at t+3+n equals n.
- Priority: layer_valid=4'b0110 with layer1=FF0000 and layer2=00FF00 -> FF0000 output; layer_valid=0 -> 000000; layer_valid=1 outside the active area -> 000000.
- Shadowing: change cfg_h_total to 99 mid-frame -> the current frame keeps 800-cycle lines; the next frame starts 100-cycle lines exactly after the v_total/h_total cycle. Set cfg_hs_pol=1 -> hs is active-high from the next frame.
- Degenerate: cfg_h_start=cfg_h_end=200 -> vga_de is never asserted, while hs, vs and sof keep running.
- Reset mid-line at h_count=400: all outputs go to their reset values immediately; after release, sof pulses and frame_cnt=1.
